// File: rtl/vec_mag_iter_if.sv
// Handshake bundle for vec_mag_iter: input vector channel plus result channel.
// The slave modport is the magnitude unit, the master modport is the environment
// that feeds vectors and consumes results.
interface vec_mag_iter_if #(
  parameter int W = 8,
  parameter int N = 2
);
  localparam int SUMW = (N == 1) ? 2*W : 2*W + $clog2(N);
  localparam int RW   = (SUMW + 1) / 2;

  logic              in_valid;
  logic              in_ready;
  logic [N*W-1:0]    in_vec;
  logic              in_round;
  logic              out_valid;
  logic              out_ready;
  logic [SUMW-1:0]   out_sumsq;
  logic [RW-1:0]     out_mag;

  modport slave (
    input  in_valid, in_vec, in_round, out_ready,
    output in_ready, out_valid, out_sumsq, out_mag
  );

  modport master (
    output in_valid, in_vec, in_round, out_ready,
    input  in_ready, out_valid, out_sumsq, out_mag
  );
endinterface

// File: rtl/vec_mag_iter.sv
// Iterative, multiplier-free Euclidean magnitude of an N-component unsigned vector.
// Sum of squares is built by shift-and-add (one component bit per cycle), then the
// integer square root is extracted with the restoring bit-pair method (one root bit
// per cycle), followed by an optional round-to-nearest correction.
module vec_mag_iter #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  vec_mag_iter_if.slave bus,
  output logic          busy
);
  localparam int SUMW = (N == 1) ? 2*W : 2*W + $clog2(N);
  localparam int RW   = (SUMW + 1) / 2;
  localparam int BW   = $clog2(W);
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  // First test bit of the root extraction: highest even bit position below SUMW.
  localparam logic [SUMW-1:0] TB0 = {{(SUMW-1){1'b0}}, 1'b1} << (2*(RW-1));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ   = 3'd1;
  localparam logic [2:0] S_SQRT = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [N*W-1:0]  vec_q, vec_d;     // remaining components, current one in the low W bits
  logic            round_q, round_d;
  logic [BW-1:0]   bit_q, bit_d;     // bit of the current component being squared
  logic [CW-1:0]   comp_q, comp_d;   // component index
  logic [SUMW-1:0] acc_q, acc_d;     // sum of squares (radicand once SQ completes)
  logic [SUMW-1:0] rem_q, rem_d;     // running remainder of the root extraction
  logic [SUMW:0]   res_q, res_d;     // root accumulator, one spare bit for res+bit
  logic [SUMW-1:0] tb_q, tb_d;       // test bit, moves two positions per step
  logic [SUMW-1:0] sumsq_q, sumsq_d;
  logic [RW-1:0]   mag_q, mag_d;

  logic [W-1:0]    cur;
  logic [SUMW-1:0] addend;
  logic [SUMW:0]   trial;
  logic [RW-1:0]   root;

  assign cur    = vec_q[W-1:0];
  assign addend = cur[bit_q] ? (SUMW'(cur) << bit_q) : '0;
  assign trial  = res_q + {1'b0, tb_q};
  assign root   = res_q[RW-1:0];

  // Next-state logic for the FSM and the whole datapath.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    round_d = round_q;
    bit_d   = bit_q;
    comp_d  = comp_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = res_q;
    tb_d    = tb_q;
    sumsq_d = sumsq_q;
    mag_d   = mag_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          vec_d   = bus.in_vec;
          round_d = bus.in_round;
          acc_d   = '0;
          bit_d   = '0;
          comp_d  = '0;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        acc_d = acc_q + addend;
        if (bit_q == BW'(W-1)) begin
          bit_d  = '0;
          vec_d  = vec_q >> W;
          comp_d = comp_q + CW'(1);
          if (comp_q == CW'(N-1)) begin
            // Radicand is final: seed the root extraction from it.
            rem_d   = acc_d;
            res_d   = '0;
            tb_d    = TB0;
            state_d = S_SQRT;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_SQRT: begin
        if ({1'b0, rem_q} >= trial) begin
          rem_d = rem_q - trial[SUMW-1:0];
          res_d = (res_q >> 1) + {1'b0, tb_q};
        end else begin
          res_d = res_q >> 1;
        end
        tb_d = tb_q >> 2;
        if (tb_q == SUMW'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        // rem > r means v exceeds (r+0.5)^2, so round up.
        mag_d   = (round_q && ({1'b0, rem_q} > res_q)) ? root + RW'(1) : root;
        sumsq_d = acc_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers: synchronous reset, en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      round_q <= 1'b0;
      bit_q   <= '0;
      comp_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      tb_q    <= '0;
      sumsq_q <= '0;
      mag_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      vec_q   <= vec_d;
      round_q <= round_d;
      bit_q   <= bit_d;
      comp_q  <= comp_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      tb_q    <= tb_d;
      sumsq_q <= sumsq_d;
      mag_q   <= mag_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_sumsq = sumsq_q;
  assign bus.out_mag   = mag_q;
  assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_vec_mag_iter.sv
// Scoreboard bench for vec_mag_iter: three instances (default 8x2, 4x3 sweep, 5x1).
// Expected results are pushed on every accepted vector and popped on every result
// transfer; latency from accept to out_valid is checked on every transaction.
module tb_vec_mag_iter;
  localparam int WA = 8, NA = 2, SA = 2*WA + $clog2(NA), RA = (SA+1)/2, LA = NA*WA + RA + 1;
  localparam int WB = 4, NB = 3, SB = 2*WB + $clog2(NB), RB = (SB+1)/2, LB = NB*WB + RB + 1;
  localparam int WC = 5, NC = 1, SC = 2*WC,              RC = (SC+1)/2, LC = NC*WC + RC + 1;

  typedef struct { longint s; longint m; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic busy_a, busy_b, busy_c;

  vec_mag_iter_if #(.W(WA), .N(NA)) ifa();
  vec_mag_iter_if #(.W(WB), .N(NB)) ifb();
  vec_mag_iter_if #(.W(WC), .N(NC)) ifc();

  vec_mag_iter #(.W(WA), .N(NA)) dut_a (.clk(clk), .rst(rst), .en(en), .bus(ifa.slave), .busy(busy_a));
  vec_mag_iter #(.W(WB), .N(NB)) dut_b (.clk(clk), .rst(rst), .en(en), .bus(ifb.slave), .busy(busy_b));
  vec_mag_iter #(.W(WC), .N(NC)) dut_c (.clk(clk), .rst(rst), .en(en), .bus(ifc.slave), .busy(busy_c));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t qa[$], qb[$], qc[$];
  longint cyc = 0, ecnt = 0;
  longint a_acc_e = 0, a_acc_c = 0, a_raw_lat = 0, b_acc_e = 0, c_acc_e = 0;
  logic a_pv = 1'b0, b_pv = 1'b0, c_pv = 1'b0;
  bit b_done = 1'b0;

  logic [15:0] dv [5] = '{16'h0403, 16'hFFFF, 16'hFFFF, 16'h0707, 16'h0101};
  bit          dr [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sumsq(input logic [63:0] v, input int w, input int n);
    longint s = 0;
    longint c;
    for (int i = 0; i < n; i++) begin
      c = longint'((v >> (i*w)) & ((64'd1 << w) - 64'd1));
      s += c * c;
    end
    return s;
  endfunction

  function automatic exp_t model(input longint s, input bit rnd, input int rw);
    exp_t e;
    longint r = 0;
    while ((r+1)*(r+1) <= s) r++;
    e.s = s;
    e.m = (rnd && (s - r*r) > r) ? r + 1 : r;
    assert (e.m < (longint'(1) << rw));
    return e;
  endfunction

  function automatic logic rdy(input int w);
    case (w)
      0:       return ifa.in_ready;
      1:       return ifb.in_ready;
      default: return ifc.in_ready;
    endcase
  endfunction

  function automatic logic ov(input int w);
    case (w)
      0:       return ifa.out_valid;
      1:       return ifb.out_valid;
      default: return ifc.out_valid;
    endcase
  endfunction

  function automatic int qsz(input int w);
    case (w)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic [63:0] v, input bit rnd, input logic vld);
    case (w)
      0: begin ifa.in_vec = v[NA*WA-1:0]; ifa.in_round = rnd; ifa.in_valid = vld; end
      1: begin ifb.in_vec = v[NB*WB-1:0]; ifb.in_round = rnd; ifb.in_valid = vld; end
      default: begin ifc.in_vec = v[NC*WC-1:0]; ifc.in_round = rnd; ifc.in_valid = vld; end
    endcase
  endtask

  // Present a vector and hold it until the accepting edge; returns at edge+#1.
  task automatic send(input int w, input logic [63:0] v, input bit rnd);
    set_in(w, v, rnd, 1'b1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (en && !rst && rdy(w)) begin
        cycle();
        set_in(w, v, rnd, 1'b0);
        return;
      end
    end
    chk("send_timeout", 0, 1);
    set_in(w, v, rnd, 1'b0);
  endtask

  task automatic drain(input int w);
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (qsz(w) == 0 && rdy(w)) return;
    end
    chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_out(input int w);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ov(w)) return;
    end
    chk("out_timeout", 0, 1);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en) ecnt <= ecnt + 1;
  end

  // Monitor A: push on accept, check latency on out_valid rise, pop on transfer.
  always @(negedge clk) begin
    if (!rst && en && ifa.in_valid && ifa.in_ready) begin
      qa.push_back(model(sumsq(64'(ifa.in_vec), WA, NA), ifa.in_round, RA));
      a_acc_e <= ecnt + 1;
      a_acc_c <= cyc + 1;
    end
    if (!rst && ifa.out_valid && !a_pv) begin
      chk("a_latency", ecnt - a_acc_e, LA);
      a_raw_lat <= cyc - a_acc_c;
    end
    a_pv <= ifa.out_valid;
    if (!rst && en && ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) chk("a_unexpected", 1, 0);
      else begin
        chk("a_sumsq", longint'(ifa.out_sumsq), qa[0].s);
        chk("a_mag", longint'(ifa.out_mag), qa[0].m);
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && en && ifb.in_valid && ifb.in_ready) begin
      qb.push_back(model(sumsq(64'(ifb.in_vec), WB, NB), ifb.in_round, RB));
      b_acc_e <= ecnt + 1;
    end
    if (!rst && ifb.out_valid && !b_pv) chk("b_latency", ecnt - b_acc_e, LB);
    b_pv <= ifb.out_valid;
    if (!rst && en && ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        chk("b_sumsq", longint'(ifb.out_sumsq), qb[0].s);
        chk("b_mag", longint'(ifb.out_mag), qb[0].m);
        void'(qb.pop_front());
      end
    end
  end

  // N=1: the magnitude is the component itself in both rounding modes.
  always @(negedge clk) begin
    if (!rst && en && ifc.in_valid && ifc.in_ready) begin
      qc.push_back('{s: longint'(ifc.in_vec) * longint'(ifc.in_vec), m: longint'(ifc.in_vec)});
      c_acc_e <= ecnt + 1;
    end
    if (!rst && ifc.out_valid && !c_pv) chk("c_latency", ecnt - c_acc_e, LC);
    c_pv <= ifc.out_valid;
    if (!rst && en && ifc.out_valid && ifc.out_ready) begin
      if (qc.size() == 0) chk("c_unexpected", 1, 0);
      else begin
        chk("c_sumsq", longint'(ifc.out_sumsq), qc[0].s);
        chk("c_mag", longint'(ifc.out_mag), qc[0].m);
        void'(qc.pop_front());
      end
    end
  end

  initial begin
    for (int w = 0; w < 3; w++) set_in(w, 64'd0, 1'b0, 1'b0);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    ifc.out_ready = 1'b1;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) cycle();
    chk("rst_in_ready", longint'(ifa.in_ready), 1);
    chk("rst_out_valid", longint'(ifa.out_valid), 0);
    chk("rst_sumsq", longint'(ifa.out_sumsq), 0);
    chk("rst_mag", longint'(ifa.out_mag), 0);
    chk("rst_busy", longint'(busy_a), 0);
    chk("rst_b_in_ready", longint'(ifb.in_ready), 1);
    chk("rst_c_out_valid", longint'(ifc.out_valid), 0);
    rst = 1'b0;
    cycle();

    // Directed vectors on the default instance.
    for (int i = 0; i < 5; i++) begin
      send(0, 64'(dv[i]), dr[i]);
      chk("busy_after_accept", longint'(busy_a), 1);
      drain(0);
    end

    // Backpressure: result held 20 cycles, a new vector is ignored meanwhile.
    ifa.out_ready = 1'b0;
    send(0, 64'h0000_FFFF, 1'b1);
    wait_out(0);
    cycle();
    set_in(0, 64'h0000_0102, 1'b0, 1'b1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_valid", longint'(ifa.out_valid), 1);
      chk("bp_in_ready", longint'(ifa.in_ready), 0);
      chk("bp_sumsq", longint'(ifa.out_sumsq), 130050);
      chk("bp_mag", longint'(ifa.out_mag), 361);
    end
    cycle();
    set_in(0, 64'h0000_0102, 1'b0, 1'b0);
    ifa.out_ready = 1'b1;
    cycle();
    chk("bp_in_ready_after", longint'(ifa.in_ready), 1);
    chk("bp_out_valid_after", longint'(ifa.out_valid), 0);
    chk("bp_one_transfer", longint'(qa.size()), 0);

    // Enable stalls: 5 cycles in SQ, 3 cycles in SQRT.
    send(0, 64'h0000_0304, 1'b0);
    repeat (3) cycle();
    en = 1'b0;
    repeat (5) cycle();
    en = 1'b1;
    repeat (15) cycle();
    en = 1'b0;
    repeat (3) cycle();
    chk("stall_busy", longint'(busy_a), 1);
    en = 1'b1;
    drain(0);
    chk("stall_raw_latency", a_raw_lat, LA + 8);

    // Reset in the middle of the root extraction discards the vector.
    send(0, 64'h0000_FFFF, 1'b0);
    repeat (20) cycle();
    rst = 1'b1;
    qa.delete();
    cycle();
    chk("mid_rst_in_ready", longint'(ifa.in_ready), 1);
    chk("mid_rst_out_valid", longint'(ifa.out_valid), 0);
    chk("mid_rst_sumsq", longint'(ifa.out_sumsq), 0);
    chk("mid_rst_mag", longint'(ifa.out_mag), 0);
    chk("mid_rst_busy", longint'(busy_a), 0);
    rst = 1'b0;
    cycle();
    send(0, 64'h0000_0000, 1'b1);
    drain(0);

    // N=1 instance: every component value in both rounding modes.
    for (int v = 0; v < (1 << WC); v++) begin
      send(2, 64'(v), 1'(v & 1));
      drain(2);
    end

    // W=4, N=3 random sweep with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(1, {32'h0, $urandom}, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) cycle();
        end
        drain(1);
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          cycle();
          ifb.out_ready = ($urandom_range(0, 2) != 0);
        end
        ifb.out_ready = 1'b1;
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
